// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, functs,
// ALU control words, datapath mux selects and the controller state enum.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  // Bit 2 inverts B with carry-in, bit 1 picks the arithmetic group,
  // bit 0 picks the second member of the group.
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXEC,
    S_ALUWB,
    S_BRANCH,
    S_ADDIEX,
    S_ADDIWB,
    S_JUMP
  } state_e;

endpackage

// File: rtl/alu_decoder.sv
// Maps an R-type funct field to the 4-bit ALU control word and flags
// whether the funct is one the datapath supports.
module alu_decoder
  import mips_pkg::*;
(
  input  logic [5:0] funct_i,
  output logic [3:0] alu_control_o,
  output logic       funct_legal_o
);

  always_comb begin
    alu_control_o = ALU_ADD;
    funct_legal_o = 1'b1;
    case (funct_i)
      FUNCT_ADD: alu_control_o = ALU_ADD;
      FUNCT_SUB: alu_control_o = ALU_SUB;
      FUNCT_AND: alu_control_o = ALU_AND;
      FUNCT_OR:  alu_control_o = ALU_OR;
      FUNCT_SLT: alu_control_o = ALU_SLT;
      default:   funct_legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// and handshakes with a unified memory via mem_req/mem_ready.
module mips_mc_controller
  import mips_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_control,
  output logic [1:0] pc_src,
  output logic       pc_en,
  output logic       illegal,
  output logic       retire
);

  state_e     state_q, state_d;
  logic       memReady;
  logic [3:0] functAluControl;
  logic       functLegal;

  assign memReady = MEM_WAIT_EN ? mem_ready : 1'b1;

  alu_decoder u_alu_decoder (
    .funct_i       (funct),
    .alu_control_o (functAluControl),
    .funct_legal_o (functLegal)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    iord        = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = SRCB_RT;
    alu_control = ALU_AND;
    pc_src      = PC_ALU;
    pc_en       = 1'b0;
    illegal     = 1'b0;
    retire      = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req     = 1'b1;
        alu_src_b   = SRCB_FOUR;
        alu_control = ALU_ADD;
        ir_write    = memReady;
        pc_en       = memReady;
        if (memReady) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b   = SRCB_IMMSH;
        alu_control = ALU_ADD;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          OP_RTYPE: begin
            state_d = functLegal ? S_EXEC : S_FETCH;
            illegal = !functLegal;
          end
          default: begin
            state_d = S_FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a   = 1'b1;
        alu_src_b   = SRCB_IMM;
        alu_control = ALU_ADD;
        state_d     = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (memReady) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        iord      = 1'b1;
        retire    = memReady;
        if (memReady) state_d = S_FETCH;
      end
      S_EXEC: begin
        alu_src_a   = 1'b1;
        alu_src_b   = SRCB_RT;
        alu_control = functAluControl;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a   = 1'b1;
        alu_src_b   = SRCB_RT;
        alu_control = ALU_SUB;
        pc_src      = PC_ALUOUT;
        pc_en       = zero;
        retire      = 1'b1;
        state_d     = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a   = 1'b1;
        alu_src_b   = SRCB_IMM;
        alu_control = ALU_ADD;
        state_d     = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_src  = PC_JUMP;
        pc_en   = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // Held reset presents an idle FETCH: no request and no side effects,
    // whatever state the register happens to hold on the first reset cycle.
    if (reset) begin
      mem_req     = 1'b0;
      mem_write   = 1'b0;
      iord        = 1'b0;
      ir_write    = 1'b0;
      reg_write   = 1'b0;
      reg_dst     = 1'b0;
      mem_to_reg  = 1'b0;
      alu_src_a   = 1'b0;
      alu_src_b   = SRCB_FOUR;
      alu_control = ALU_ADD;
      pc_src      = PC_ALU;
      pc_en       = 1'b0;
      illegal     = 1'b0;
      retire      = 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_mc_controller.sv
// Randomized self-checking bench for mips_mc_controller: each instruction is
// expanded into its list of phases and every cycle's outputs are compared.
module tb_mips_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic       mem_req, mem_write, iord, ir_write, reg_write, reg_dst, mem_to_reg;
  logic       alu_src_a, pc_en, illegal, retire;
  logic [1:0] alu_src_b, pc_src;
  logic [3:0] alu_control;
  logic [18:0] obsVec;

  int vectorsApplied = 0;
  int miscompares    = 0;
  int retireSeen     = 0;
  int retireExpected = 0;

  mips_mc_controller #(.MEM_WAIT_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write), .iord(iord),
    .ir_write(ir_write), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_control(alu_control), .pc_src(pc_src), .pc_en(pc_en),
    .illegal(illegal), .retire(retire)
  );

  always #5 clk = ~clk;

  assign obsVec = {mem_req, mem_write, iord, ir_write, reg_write, reg_dst, mem_to_reg,
                   alu_src_a, alu_src_b, alu_control, pc_src, pc_en, illegal, retire};

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorsApplied++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [3:0] aluFor(input logic [5:0] fn);
    case (fn)
      6'h20:   return 4'b0010;
      6'h22:   return 4'b0110;
      6'h24:   return 4'b0000;
      6'h25:   return 4'b0001;
      6'h2A:   return 4'b0111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic bit isLegal(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h00) return (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A});
    return (op inside {6'h23, 6'h2B, 6'h04, 6'h08, 6'h02});
  endfunction

  // F fetch, D decode, A memadr, R memrd, L memwb, S memwr, E exec,
  // W aluwb, B branch, I addiex, K addiwb, J jump
  function automatic string phasesFor(input logic [5:0] op, input logic [5:0] fn);
    if (!isLegal(op, fn)) return "FD";
    case (op)
      6'h00:   return "FDEW";
      6'h23:   return "FDARL";
      6'h2B:   return "FDAS";
      6'h04:   return "FDB";
      6'h08:   return "FDIK";
      default: return "FDJ";
    endcase
  endfunction

  function automatic logic [18:0] expOut(input byte ph, input logic z, input logic rdy,
                                         input logic [5:0] op, input logic [5:0] fn,
                                         input logic rst);
    logic mreq = 0, mwr = 0, ad = 0, irw = 0, rw = 0, rdst = 0, m2r = 0, srca = 0;
    logic pcen = 0, ill = 0, ret = 0;
    logic [1:0] srcb = 2'b00, pcs = 2'b00;
    logic [3:0] alu = 4'b0000;
    if (rst) begin
      srcb = 2'b01; alu = 4'b0010;
    end else begin
      case (ph)
        "F": begin mreq = 1; srcb = 2'b01; alu = 4'b0010; irw = rdy; pcen = rdy; end
        "D": begin srcb = 2'b11; alu = 4'b0010; ill = !isLegal(op, fn); end
        "A": begin srca = 1; srcb = 2'b10; alu = 4'b0010; end
        "R": begin mreq = 1; ad = 1; end
        "L": begin rw = 1; m2r = 1; ret = 1; end
        "S": begin mreq = 1; mwr = 1; ad = 1; ret = rdy; end
        "E": begin srca = 1; alu = aluFor(fn); end
        "W": begin rw = 1; rdst = 1; ret = 1; end
        "B": begin srca = 1; alu = 4'b0110; pcs = 2'b01; pcen = z; ret = 1; end
        "I": begin srca = 1; srcb = 2'b10; alu = 4'b0010; end
        "K": begin rw = 1; ret = 1; end
        "J": begin pcs = 2'b10; pcen = 1; ret = 1; end
        default: ;
      endcase
    end
    return {mreq, mwr, ad, irw, rw, rdst, m2r, srca, srcb, alu, pcs, pcen, ill, ret};
  endfunction

  // Drive one cycle's inputs, check at the falling edge, then advance.
  task automatic applyStimulus(input byte ph, input logic rdy, input logic z,
                               input logic rst, input string tag);
    mem_ready = rdy;
    zero      = z;
    reset     = rst;
    @(negedge clk);
    checkOutput(tag, {13'd0, obsVec}, {13'd0, expOut(ph, z, rdy, opcode, funct, rst)});
    if (retire === 1'b1) retireSeen++;
    @(posedge clk);
    #1;
  endtask

  task automatic runInstr(input logic [5:0] op, input logic [5:0] fn, input int fetchWaits,
                          input int memWaits, input logic z, input string tag);
    string ph;
    ph = phasesFor(op, fn);
    opcode = op;
    funct  = fn;
    if (isLegal(op, fn)) retireExpected++;
    for (int i = 0; i < ph.len(); i++) begin
      byte p;
      int  waits;
      p = ph[i];
      waits = (p == "F") ? fetchWaits : ((p == "R" || p == "S") ? memWaits : 0);
      for (int w = 0; w <= waits; w++) begin
        logic rdy, zv;
        rdy = (p == "F" || p == "R" || p == "S") ? (w == waits) : 1'($urandom_range(0, 1));
        zv  = (p == "B") ? z : 1'($urandom_range(0, 1));
        applyStimulus(p, rdy, zv, 1'b0, $sformatf("%s_%c%0d", tag, p, w));
      end
    end
  endtask

  task automatic resetInMemwr();
    opcode = 6'h2B;
    funct  = 6'h00;
    applyStimulus("F", 1'b1, 1'b0, 1'b0, "swrst_F");
    applyStimulus("D", 1'b1, 1'b0, 1'b0, "swrst_D");
    applyStimulus("A", 1'b1, 1'b0, 1'b0, "swrst_A");
    applyStimulus("S", 1'b0, 1'b0, 1'b0, "swrst_S_wait");
    applyStimulus("S", 1'b0, 1'b0, 1'b1, "swrst_S_reset");
  endtask

  initial begin
    logic [5:0] op, fn;
    reset = 1'b1; mem_ready = 1'b1; zero = 1'b0; opcode = 6'h00; funct = 6'h20;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) applyStimulus("F", 1'b1, 1'b0, 1'b1, "reset_hold");

    runInstr(6'h00, 6'h2A, 0, 0, 1'b0, "slt");
    runInstr(6'h23, 6'h00, 0, 2, 1'b0, "lw_wait2");
    runInstr(6'h04, 6'h00, 0, 0, 1'b1, "beq_taken");
    runInstr(6'h04, 6'h00, 0, 0, 1'b0, "beq_nottaken");
    runInstr(6'h3F, 6'h00, 0, 0, 1'b0, "illegal_op");
    runInstr(6'h00, 6'h27, 0, 0, 1'b0, "illegal_funct");
    runInstr(6'h2B, 6'h00, 1, 1, 1'b0, "sw_wait");
    runInstr(6'h08, 6'h00, 0, 0, 1'b0, "addi");
    runInstr(6'h02, 6'h00, 2, 0, 1'b0, "jump");
    resetInMemwr();

    for (int n = 0; n < 300; n++) begin
      int kind;
      kind = $urandom_range(0, 7);
      fn = 6'($urandom_range(0, 63));
      case (kind)
        0: begin
          op = 6'h00;
          case ($urandom_range(0, 4))
            0: fn = 6'h20; 1: fn = 6'h22; 2: fn = 6'h24; 3: fn = 6'h25; default: fn = 6'h2A;
          endcase
        end
        1: op = 6'h23;
        2: op = 6'h2B;
        3: op = 6'h04;
        4: op = 6'h08;
        5: op = 6'h02;
        6: begin
          op = 6'h00;
          while (isLegal(op, fn)) fn = 6'($urandom_range(0, 63));
        end
        default: begin
          op = 6'($urandom_range(1, 63));
          while (isLegal(op, fn)) op = 6'($urandom_range(1, 63));
        end
      endcase
      runInstr(op, fn, $urandom_range(0, 2), $urandom_range(0, 2),
               1'($urandom_range(0, 1)), $sformatf("rnd%0d", n));
    end

    checkOutput("retire_count", retireSeen, retireExpected);
    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
